uart_rx_frame: RTL and testbench

Parametrised UART receiver: the successor to the fixed 8N1 `uart_rx`. It receives asynchronous serial frames on `rx_bit` and handles these at elaboration time:
- configurable baud divisor;
- 5–9 data bits;
- none, odd or even parity;
- 1 or 2 stop bits.

It adds an input synchroniser, false-start rejection, a one-cycle `rx_valid` strobe, parity/framing error flags and break recovery. It sits directly behind the pad/loopback from `uart_tx` and feeds byte-level consumers in the same `clk` domain.

---
 rtl/uart_rx_frame.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 2-flop input synchroniser, false-start rejection, parity/framing flags, break recovery.
// Latency: rx_valid pulses the cycle after the final stop-bit sample (2 cycles of synchroniser delay before start detection).
// Backpressure: none; consumers must take data_word/flags on the rx_valid strobe, which are held until the next one.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_bit,
    output logic [DATA_BITS-1:0] data_word,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_active
);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx_frame: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_dbits
        $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 perr_pend;
    logic                 ferr_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            perr_pend  <= 1'b0;
            ferr_pend  <= 1'b0;
            data_word  <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_active  <= 1'b0;
        end else begin
            sync1    <= rx_bit;
            rxs      <= sync1;
            rx_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state     <= S_START;
                        cnt       <= '0;
                        rx_active <= 1'b1;
                    end
                end

                // Mid-start sample: a line already back high was only a glitch.
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        if (rxs) begin
                            state     <= S_IDLE;
                            rx_active <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            cnt       <= '0;
                            bit_idx   <= '0;
                            stop_idx  <= 1'b0;
                            par_acc   <= 1'b0;
                            perr_pend <= 1'b0;
                            ferr_pend <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ rxs;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_PAR: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        perr_pend <= (PARITY == 1) ? ~(par_acc ^ rxs) : (par_acc ^ rxs);
                        state     <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            data_word  <= shreg;
                            parity_err <= (PARITY != 0) && perr_pend;
                            frame_err  <= ferr_pend | ~rxs;
                            rx_valid   <= 1'b1;
                            if (ferr_pend | ~rxs) begin
                                state <= S_WAIT_HIGH;
                            end else begin
                                state     <= S_IDLE;
                                rx_active <= 1'b0;
                            end
                        end else begin
                            stop_idx  <= 1'b1;
                            ferr_pend <= ferr_pend | ~rxs;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A held-low (break) line must produce one errored frame, not a stream.
                S_WAIT_HIGH: begin
                    if (rxs) begin
                        state     <= S_IDLE;
                        rx_active <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    rx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three configurations (8N1/87, 8E1/16, 7O2/16) driven serially, scoreboarded on rx_valid.
module tb_uart_rx_frame;

    localparam int CPB_A = 87;
    localparam int CPB_B = 16;
    localparam int CPB_C = 16;

    typedef struct {
        int unsigned dw;
        bit          pe;
        bit          fe;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx [3];
    logic [7:0] dw_a;
    logic [7:0] dw_b;
    logic [6:0] dw_c;
    logic [8:0] dw  [3];
    logic       vld [3];
    logic       pe  [3];
    logic       fe  [3];
    logic       act [3];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q [3][$];
    int unsigned last_dw [3];
    bit   last_pe [3];
    bit   last_fe [3];
    logic prev_vld [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .rx_bit(rx[0]), .data_word(dw_a), .rx_valid(vld[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .rx_active(act[0]));
    uart_rx_frame #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .rx_bit(rx[1]), .data_word(dw_b), .rx_valid(vld[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .rx_active(act[1]));
    uart_rx_frame #(.CLKS_PER_BIT(CPB_C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .rx_bit(rx[2]), .data_word(dw_c), .rx_valid(vld[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .rx_active(act[2]));

    assign dw[0] = {1'b0, dw_a};
    assign dw[1] = {1'b0, dw_b};
    assign dw[2] = {2'b00, dw_c};

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    last_dw[i] = 0;
                    last_pe[i] = 1'b0;
                    last_fe[i] = 1'b0;
                end else if (vld[i] === 1'b1) begin
                    check("double_strobe", prev_vld[i], 0);
                    check("unexpected_strobe", sb_q[i].size() != 0, 1);
                    if (sb_q[i].size() != 0) begin
                        exp_t e = sb_q[i].pop_front();
                        check("data_word", dw[i], e.dw);
                        check("parity_err", pe[i], e.pe);
                        check("frame_err", fe[i], e.fe);
                        check("strobe_cycle", cyc, e.cyc);
                        last_dw[i] = e.dw;
                        last_pe[i] = e.pe;
                        last_fe[i] = e.fe;
                    end
                end
                prev_vld[i] = vld[i];
            end
        end
    endtask

    // Caller must be at a negedge; the frame's first edge is seen by the DUT 3 posedges later.
    task automatic send(input int inst, input int data, input int dbits, input int par,
                        input bit flip, input int stops, input bit last_stop_low, input int cpb);
        logic [15:0] fr;
        int   n;
        int   dm;
        bit   pb;
        exp_t e;
        fr = '0;
        n = 0;
        dm = data & ((1 << dbits) - 1);
        fr[n] = 1'b0; n++;
        for (int i = 0; i < dbits; i++) begin
            fr[n] = dm[i]; n++;
        end
        if (par != 0) begin
            pb = (par == 1) ? ~(^dm) : (^dm);
            fr[n] = pb ^ flip; n++;
        end
        for (int i = 0; i < stops; i++) begin
            fr[n] = (i == stops - 1) ? ~last_stop_low : 1'b1; n++;
        end
        e.dw  = dm;
        e.pe  = (par != 0) && flip;
        e.fe  = last_stop_low;
        e.cyc = cyc + 3 + (cpb - 1) / 2 + (n - 1) * cpb;
        sb_q[inst].push_back(e);
        for (int i = 0; i < n; i++) begin
            rx[inst] = fr[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    initial begin
        int total;
        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1;
            prev_vld[i] = 1'b0;
            last_dw[i] = 0;
            last_pe[i] = 1'b0;
            last_fe[i] = 1'b0;
        end
        fork
            monitor_loop();
        join_none
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_data", dw[i], 0);
            check("reset_valid", vld[i], 0);
            check("reset_flags", {pe[i], fe[i]}, 0);
            check("reset_active", act[i], 0);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 8N1 basic frame
        send(0, 8'hA5, 8, 0, 1'b0, 1, 1'b0, CPB_A);
        repeat (2 * CPB_A) @(negedge clk);

        // Glitch shorter than half a bit
        rx[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_active_high", act[0], 1);
        repeat (10) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * CPB_A) @(negedge clk);
        check("glitch_active_low", act[0], 0);
        check("glitch_data_held", dw[0], last_dw[0]);
        check("glitch_flags_held", {pe[0], fe[0]}, {last_pe[0], last_fe[0]});

        // Back-to-back frames, no idle gap
        send(0, 8'h00, 8, 0, 1'b0, 1, 1'b0, CPB_A);
        send(0, 8'hFF, 8, 0, 1'b0, 1, 1'b0, CPB_A);
        repeat (2 * CPB_A) @(negedge clk);

        // Framing error followed by a long break, then recovery
        send(0, 8'h55, 8, 0, 1'b0, 1, 1'b1, CPB_A);
        repeat (30 * CPB_A) @(negedge clk);
        check("break_active", act[0], 1);
        rx[0] = 1'b1;
        repeat (2 * CPB_A) @(negedge clk);
        check("break_recovered", act[0], 0);
        send(0, 8'h12, 8, 0, 1'b0, 1, 1'b0, CPB_A);
        repeat (2 * CPB_A) @(negedge clk);

        // Reset during data bit 4: no strobe, outputs cleared
        rx[0] = 1'b0;
        repeat (CPB_A) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx[0] = i[0];
            repeat (CPB_A) @(negedge clk);
        end
        rx[0] = 1'b0;
        repeat (CPB_A / 2) @(negedge clk);
        rst = 1'b1;
        rx[0] = 1'b1;
        @(negedge clk);
        check("midrst_data", dw[0], 0);
        check("midrst_valid", vld[0], 0);
        check("midrst_flags", {pe[0], fe[0]}, 0);
        check("midrst_active", act[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB_A) @(negedge clk);
        check("midrst_idle", act[0], 0);

        // 8E1: correct parity, then flipped parity
        send(1, 8'h3C, 8, 2, 1'b0, 1, 1'b0, CPB_B);
        repeat (2 * CPB_B) @(negedge clk);
        send(1, 8'h3C, 8, 2, 1'b1, 1, 1'b0, CPB_B);
        repeat (2 * CPB_B) @(negedge clk);

        // 7O2: clean, second stop low, then bad parity
        send(2, 7'h5A, 7, 1, 1'b0, 2, 1'b0, CPB_C);
        repeat (2 * CPB_C) @(negedge clk);
        send(2, 7'h33, 7, 1, 1'b0, 2, 1'b1, CPB_C);
        rx[2] = 1'b1;
        repeat (3 * CPB_C) @(negedge clk);
        send(2, 7'h41, 7, 1, 1'b1, 2, 1'b0, CPB_C);

        total = sb_q[0].size() + sb_q[1].size() + sb_q[2].size();
        for (int k = 0; k < 3000 && total > 0; k++) begin
            @(negedge clk);
            total = sb_q[0].size() + sb_q[1].size() + sb_q[2].size();
        end
        check("scoreboard_drained", total, 0);
        repeat (4 * CPB_A) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
